wine_feature_sequencer: RTL and testbench

WINE_FEATURE_SEQUENCER -- requirements
Module: wine_feature_sequencer

---
 rtl/wine_seq_pkg.sv | 15 +
 rtl/wine_feat_packer.sv | 45 ++++
 rtl/wine_feature_sequencer.sv | 109 ++++++++++
 tb/tb_wine_feature_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wine_seq_pkg.sv
// Shared state encoding and default dimensions for the wine feature sequencer.
package wine_seq_pkg;

  localparam int NUM_FEAT = 11;
  localparam int FEAT_W   = 4;
  localparam int OUT_W    = 20;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/wine_feat_packer.sv
// Beat index counter plus packed feature register that drives the classifier input.
module wine_feat_packer #(
  parameter int NUM_FEAT = wine_seq_pkg::NUM_FEAT,
  parameter int FEAT_W   = wine_seq_pkg::FEAT_W,
  parameter int IDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       clr,
  input  logic [FEAT_W-1:0]          wr_data,
  output logic [IDX_W-1:0]           idx,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_word
);

  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_FEAT*FEAT_W-1:0] word_q, word_d;

  // A write lands in the slot of the current index; clear wins over the increment.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (wr_en) begin
      word_d[FEAT_W*idx_q +: FEAT_W] = wr_data;
      idx_d = idx_q + IDX_W'(1);
    end
    if (clr) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign idx       = idx_q;
  assign feat_word = word_q;

endmodule

// File: rtl/wine_feature_sequencer.sv
// Collects one frame of features, lets the external classifier settle, then offers its result.
module wine_feature_sequencer #(
  parameter int NUM_FEAT    = wine_seq_pkg::NUM_FEAT,
  parameter int FEAT_W      = wine_seq_pkg::FEAT_W,
  parameter int OUT_W       = wine_seq_pkg::OUT_W,
  parameter int EVAL_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  input  logic                       feat_last,
  output logic [NUM_FEAT*FEAT_W-1:0] mlp_inp,
  input  logic [OUT_W-1:0]           mlp_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_data,
  output logic                       frame_err
);

  import wine_seq_pkg::*;

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   res_data_q, res_data_d;
  logic               frame_err_q, frame_err_d;

  logic [IDX_W-1:0]   idx;
  logic               last_idx;
  logic               feat_xfer;
  logic               res_xfer;
  logic               frame_bad;
  logic               pk_wr_en;
  logic               pk_clr;

  assign feat_ready = (state_q == LOAD) && !rst;
  assign res_valid  = (state_q == HOLD);
  assign feat_xfer  = feat_valid && feat_ready;
  assign res_xfer   = res_valid && res_ready;
  assign last_idx   = (idx == IDX_W'(NUM_FEAT - 1));
  // A frame is bad when feat_last and the final index disagree.
  assign frame_bad  = feat_last ^ last_idx;
  assign pk_wr_en   = feat_xfer && !frame_bad;
  assign pk_clr     = (feat_xfer && (feat_last || last_idx)) || res_xfer;

  wine_feat_packer #(
    .NUM_FEAT (NUM_FEAT),
    .FEAT_W   (FEAT_W),
    .IDX_W    (IDX_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (pk_wr_en),
    .clr       (pk_clr),
    .wr_data   (feat_data),
    .idx       (idx),
    .feat_word (mlp_inp)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    frame_err_d = feat_xfer && frame_bad;
    unique case (state_q)
      LOAD: begin
        if (feat_xfer && feat_last && last_idx) begin
          state_d = EVAL;
          cnt_d   = CNT_W'(EVAL_CYCLES - 1);
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          res_data_d = mlp_out;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (res_xfer) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      res_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign res_data  = res_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_wine_feature_sequencer.sv
// Directed self-checking bench for wine_feature_sequencer with a stand-in classifier.
module tb_wine_feature_sequencer;

  localparam int NUM_FEAT    = 11;
  localparam int FEAT_W      = 4;
  localparam int OUT_W       = 20;
  localparam int EVAL_CYCLES = 2;
  localparam int IN_W        = NUM_FEAT * FEAT_W;

  logic              clk;
  logic              rst;
  logic              feat_valid;
  logic              feat_ready;
  logic [FEAT_W-1:0] feat_data;
  logic              feat_last;
  logic [IN_W-1:0]   mlp_inp;
  logic [OUT_W-1:0]  mlp_out;
  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  res_data;
  logic              frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  wine_feature_sequencer #(
    .NUM_FEAT    (NUM_FEAT),
    .FEAT_W      (FEAT_W),
    .OUT_W       (OUT_W),
    .EVAL_CYCLES (EVAL_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .feat_last  (feat_last),
    .mlp_inp    (mlp_inp),
    .mlp_out    (mlp_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .frame_err  (frame_err)
  );

  // Stand-in classifier: known anchor points, otherwise a value using the top output bits.
  function automatic logic [OUT_W-1:0] cls(input logic [IN_W-1:0] v);
    if (v == '0)       return 20'd22722;
    else if (&v)       return 20'd22704;
    else               return v[OUT_W-1:0] ^ 20'hA0000;
  endfunction

  always_comb mlp_out = cls(mlp_inp);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [FEAT_W-1:0] d, input logic l);
    checkOutput("feat_ready_in_load", 64'(feat_ready), 64'd1);
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = l;
    step();
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  // mode 0: zeros, 1: all fifteen, 2: beat number (1-based) mod 16
  task automatic sendBeats(input int n, input int mode, input int last_at);
    logic [FEAT_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = '0;
        1:       d = 4'hF;
        default: d = FEAT_W'((i + 1) % 16);
      endcase
      applyStimulus(d, i == last_at);
    end
  endtask

  task automatic waitResult(input logic [OUT_W-1:0] exp);
    for (int k = 1; k <= EVAL_CYCLES; k++) begin
      checkOutput("res_valid_during_eval", 64'(res_valid), 64'd0);
      checkOutput("feat_ready_during_eval", 64'(feat_ready), 64'd0);
      step();
    end
    checkOutput("res_valid_latency", 64'(res_valid), 64'd1);
    checkOutput("res_data", 64'(res_data), 64'(exp));
  endtask

  task automatic takeResult();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checkOutput("res_valid_after_take", 64'(res_valid), 64'd0);
    checkOutput("feat_ready_after_take", 64'(feat_ready), 64'd1);
  endtask

  initial begin
    logic [IN_W-1:0] cnt_word;
    cnt_word   = 44'hBA987654321;
    rst        = 1'b1;
    feat_valid = 1'b0;
    feat_data  = '0;
    feat_last  = 1'b0;
    res_ready  = 1'b0;

    step();
    step();
    checkOutput("rst_feat_ready", 64'(feat_ready), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_mlp_inp", 64'(mlp_inp), 64'd0);
    checkOutput("rst_res_data", 64'(res_data), 64'd0);
    checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("feat_ready_after_rst", 64'(feat_ready), 64'd1);

    $display("[TB] all-zero frame");
    sendBeats(NUM_FEAT, 0, NUM_FEAT - 1);
    checkOutput("zero_mlp_inp", 64'(mlp_inp), 64'd0);
    waitResult(20'd22722);
    takeResult();

    $display("[TB] all-fifteen frame");
    sendBeats(NUM_FEAT, 1, NUM_FEAT - 1);
    checkOutput("ones_mlp_inp", 64'(mlp_inp), 64'hFFFFFFFFFFF);
    waitResult(20'd22704);
    takeResult();

    $display("[TB] counting frame with stalled result and offered beats");
    sendBeats(NUM_FEAT, 2, NUM_FEAT - 1);
    checkOutput("count_mlp_inp_eval", 64'(mlp_inp), 64'(cnt_word));
    feat_valid = 1'b1;
    feat_data  = 4'h7;
    waitResult(20'hF4321);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("hold_res_data", 64'(res_data), 64'hF4321);
      checkOutput("hold_res_valid", 64'(res_valid), 64'd1);
      checkOutput("hold_feat_ready", 64'(feat_ready), 64'd0);
      checkOutput("hold_mlp_inp", 64'(mlp_inp), 64'(cnt_word));
    end
    feat_valid = 1'b0;
    takeResult();
    checkOutput("count_mlp_inp_load", 64'(mlp_inp), 64'(cnt_word));

    $display("[TB] early feat_last on beat 5");
    sendBeats(5, 1, 4);
    checkOutput("early_last_frame_err", 64'(frame_err), 64'd1);
    checkOutput("early_last_feat_ready", 64'(feat_ready), 64'd1);
    step();
    checkOutput("early_last_err_pulse_end", 64'(frame_err), 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("early_last_no_result", 64'(res_valid), 64'd0);
      step();
    end
    sendBeats(NUM_FEAT, 0, NUM_FEAT - 1);
    waitResult(20'd22722);
    takeResult();

    $display("[TB] missing feat_last on final beat");
    sendBeats(NUM_FEAT, 1, -1);
    checkOutput("no_last_frame_err", 64'(frame_err), 64'd1);
    step();
    checkOutput("no_last_err_pulse_end", 64'(frame_err), 64'd0);
    checkOutput("no_last_no_eval", 64'(feat_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("no_last_no_result", 64'(res_valid), 64'd0);
      step();
    end
    sendBeats(NUM_FEAT, 2, NUM_FEAT - 1);
    checkOutput("after_no_last_mlp_inp", 64'(mlp_inp), 64'(cnt_word));
    waitResult(20'hF4321);
    takeResult();

    $display("[TB] reset during EVAL");
    sendBeats(NUM_FEAT, 1, NUM_FEAT - 1);
    rst = 1'b1;
    step();
    checkOutput("rst_eval_mlp_inp", 64'(mlp_inp), 64'd0);
    checkOutput("rst_eval_res_data", 64'(res_data), 64'd0);
    checkOutput("rst_eval_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_eval_feat_ready", 64'(feat_ready), 64'd0);
    checkOutput("rst_eval_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < EVAL_CYCLES + 2; k++) begin
      step();
      checkOutput("rst_eval_no_result", 64'(res_valid), 64'd0);
      checkOutput("rst_eval_no_err", 64'(frame_err), 64'd0);
    end

    $display("[TB] reset during HOLD");
    sendBeats(NUM_FEAT, 1, NUM_FEAT - 1);
    waitResult(20'd22704);
    rst = 1'b1;
    step();
    checkOutput("rst_hold_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_hold_res_data", 64'(res_data), 64'd0);
    checkOutput("rst_hold_mlp_inp", 64'(mlp_inp), 64'd0);
    checkOutput("rst_hold_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("rst_hold_feat_ready", 64'(feat_ready), 64'd1);
    checkOutput("rst_hold_no_result", 64'(res_valid), 64'd0);
    checkOutput("rst_hold_no_err", 64'(frame_err), 64'd0);

    sendBeats(NUM_FEAT, 0, NUM_FEAT - 1);
    waitResult(20'd22722);
    takeResult();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
